// File: rtl/mul_wb_seq_pkg.sv
// Shared encodings for the iterative multiplier and the main decoder.
package mul_wb_seq_pkg;

  localparam int MUL_ITERS = 32;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_UMULL = 2'b01,
    OP_SMULL = 2'b10,
    OP_RSVD  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CALC = 3'd1,
    ST_SIGN = 3'd2,
    ST_WRLO = 3'd3,
    ST_WRHI = 3'd4
  } mul_state_e;

  // Long ops write two beats (Rd low, Ra high); everything else is one beat.
  function automatic logic is_long(input logic [1:0] op);
    return (op == OP_UMULL) || (op == OP_SMULL);
  endfunction

endpackage

// File: rtl/mul_shift_add_core.sv
// Radix-2 shift-add datapath: accumulator, multiplicand/multiplier shifters
// and iteration counter. Controlled by load/step/negate from the sequencer.
module mul_shift_add_core #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 negate,
  input  logic [WIDTH-1:0]     mcand_i,
  input  logic [WIDTH-1:0]     mplier_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic                 last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  // Next-state for the datapath: load wins, then an iteration, then negation.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    if (load) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, mcand_i};
      mplier_d = mplier_i;
      cnt_d    = '0;
    end else if (step) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end else if (negate) begin
      acc_d = -acc_q;
    end
  end

  // Datapath registers; reset clears everything so no stale product survives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_o  = acc_q;
  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_wb_seq.sv
// Iterative multiplier feeding the register-file write port: runs the
// shift-add core, fixes the sign for SMULL, then emits one or two write beats.
module mul_wb_seq
  import mul_wb_seq_pkg::*;
#(
  parameter int WIDTH = MUL_ITERS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             we3_o,
  output logic             we4_o,
  output logic [WIDTH-1:0] wd3_o
);

  mul_state_e state_q, state_d;
  logic long_q, long_d, neg_q, neg_d;
  logic busy_q, busy_d, done_q, done_d, we3_q, we3_d, we4_q, we4_d;
  logic [WIDTH-1:0] wd3_q, wd3_d;

  logic load, step, negate, last, smull;
  logic [WIDTH-1:0]   a_mag, b_mag, mcand, mplier;
  logic [2*WIDTH-1:0] acc, fin;

  mul_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .negate  (negate),
    .mcand_i (mcand),
    .mplier_i(mplier),
    .acc_o   (acc),
    .last_o  (last)
  );

  // |x| as unsigned: the most negative value maps to itself, which is exact.
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign smull = (op == OP_SMULL);
  // Signed result seen one cycle early, so the low beat can be registered
  // on the same edge the core performs its negation.
  assign fin   = neg_q ? -acc : acc;

  // Sequencer next state plus registered-output next values (Moore).
  always_comb begin
    state_d = state_q;
    long_d  = long_q;
    neg_d   = neg_q;
    load    = 1'b0;
    step    = 1'b0;
    negate  = 1'b0;
    mcand   = a;
    mplier  = b;
    case (state_q)
      ST_IDLE: if (start) begin
        load    = 1'b1;
        long_d  = is_long(op);
        neg_d   = smull & (a[WIDTH-1] ^ b[WIDTH-1]);
        mcand   = smull ? a_mag : a;
        mplier  = smull ? b_mag : b;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        step = 1'b1;
        if (last) state_d = ST_SIGN;
      end
      ST_SIGN: begin
        negate  = neg_q;
        state_d = ST_WRLO;
      end
      ST_WRLO: state_d = long_q ? ST_WRHI : ST_IDLE;
      ST_WRHI: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    we3_d  = (state_d == ST_WRLO) || (state_d == ST_WRHI);
    we4_d  = (state_d == ST_WRHI);
    done_d = ((state_d == ST_WRLO) && !long_q) || (state_d == ST_WRHI);
    wd3_d  = '0;
    if (state_d == ST_WRLO)      wd3_d = fin[WIDTH-1:0];
    else if (state_d == ST_WRHI) wd3_d = acc[2*WIDTH-1:WIDTH];
  end

  // State, latched op info and all outputs; reset drops any write beat at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      long_q  <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we3_q   <= 1'b0;
      we4_q   <= 1'b0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      long_q  <= long_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we3_q   <= we3_d;
      we4_q   <= we4_d;
      wd3_q   <= wd3_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign we3_o = we3_q;
  assign we4_o = we4_q;
  assign wd3_o = wd3_q;

endmodule
